// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared encodings for the barrel shifter/rotator.
//   DIR_LEFT / DIR_RIGHT     : value of a direction bit that selects left/right
//   MODE_ROTATE / MODE_SHIFT : value of rotate_en that selects rotate/logical shift
// -----------------------------------------------------------------------------
package shifter_pkg;

    localparam logic DIR_LEFT    = 1'b1;
    localparam logic DIR_RIGHT   = 1'b0;
    localparam logic MODE_ROTATE = 1'b1;
    localparam logic MODE_SHIFT  = 1'b0;

    // The direction bit that matters depends on the mode.
    // The unused direction bit is never looked at, so an X on it cannot
    // reach the datapath.
    function automatic logic select_dir(input logic rotate_en,
                                        input logic shift_dir,
                                        input logic rotate_dir);
        logic dir_s;
        if (rotate_en == MODE_ROTATE) begin
            dir_s = rotate_dir;
        end else begin
            dir_s = shift_dir;
        end
        return dir_s;
    endfunction

endpackage : shifter_pkg

// File: rtl/barrel_shift_comb.sv
// -----------------------------------------------------------------------------
// barrel_shift_comb
// Purely combinational log-depth shift/rotate network.
// Stage j moves the data by 2^j positions when sh[j] is set. The bits that
// enter from the open end are either the bits that fell off the other end
// (rotate) or zeros (logical shift).
// Ports:
//   in        [WIDTH-1:0] operand
//   sh        [SH_W-1:0]  amount, 0..WIDTH-1
//   rotate_en             MODE_ROTATE / MODE_SHIFT
//   left                  DIR_LEFT / DIR_RIGHT (already resolved for the mode)
//   out       [WIDTH-1:0] result
// -----------------------------------------------------------------------------
module barrel_shift_comb
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    input  logic [SH_W-1:0]  sh,
    input  logic             rotate_en,
    input  logic             left,
    output logic [WIDTH-1:0] out
);

    // stage_s[0] is the operand; stage_s[SH_W] is the final result.
    logic [WIDTH-1:0] stage_s [0:SH_W];

    assign stage_s[0] = in;

    for (genvar j = 0; j < SH_W; j++) begin : g_stage
        localparam int K = 1 << j;

        logic [WIDTH-1:0] d_s;
        logic [WIDTH-1:0] mv_s;

        assign d_s = stage_s[j];

        // Data moved by K places, with the wrap bits or zeros as the fill.
        always_comb begin
            mv_s = d_s;
            if (left == DIR_LEFT) begin
                if (rotate_en == MODE_ROTATE) begin
                    mv_s = {d_s[WIDTH-1-K:0], d_s[WIDTH-1:WIDTH-K]};
                end else begin
                    mv_s = {d_s[WIDTH-1-K:0], {K{1'b0}}};
                end
            end else begin
                if (rotate_en == MODE_ROTATE) begin
                    mv_s = {d_s[K-1:0], d_s[WIDTH-1:K]};
                end else begin
                    mv_s = {{K{1'b0}}, d_s[WIDTH-1:K]};
                end
            end
        end

        assign stage_s[j+1] = sh[j] ? mv_s : d_s;
    end

    assign out = stage_s[SH_W];

endmodule : barrel_shift_comb

// File: rtl/barrel_shifter_unit.sv
// -----------------------------------------------------------------------------
// barrel_shifter_unit
// Registered shift/rotate unit with a fixed latency of one cycle.
// Ports:
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   in_valid              capture in/sh/controls this cycle
//   in       [WIDTH-1:0]  operand
//   sh       [SH_W-1:0]   amount, 0..WIDTH-1
//   rotate_en             1 = rotate, 0 = logical shift
//   shift_left_right      direction in shift mode (1 = left)
//   rotate_left_right     direction in rotate mode (1 = left)
//   out_valid             out holds a result captured on the last edge
//   out      [WIDTH-1:0]  registered result; holds while in_valid is low
// -----------------------------------------------------------------------------
module barrel_shifter_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [SH_W-1:0]  sh,
    input  logic             rotate_en,
    input  logic             shift_left_right,
    input  logic             rotate_left_right,
    output logic             out_valid,
    output logic [WIDTH-1:0] out
);

    logic             left_s;
    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    assign left_s = select_dir(rotate_en, shift_left_right, rotate_left_right);

    barrel_shift_comb #(
        .WIDTH (WIDTH),
        .SH_W  (SH_W)
    ) u_net (
        .in        (in),
        .sh        (sh),
        .rotate_en (rotate_en),
        .left      (left_s),
        .out       (res_s)
    );

    // Next-state: capture a new result only for a valid request.
    always_comb begin
        out_d   = out_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d = res_s;
        end else begin
            out_d = out_q;
        end
    end

    // Output registers; reset clears any result in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule : barrel_shifter_unit

// File: tb/tb_barrel_shifter_unit.sv
module tb_barrel_shifter_unit;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in;
    logic [SW-1:0] sh;
    logic          rotate_en;
    logic          shift_left_right;
    logic          rotate_left_right;
    logic          out_valid;
    logic [W-1:0]  out;

    int checks;
    int errors;

    barrel_shifter_unit #(.WIDTH(W), .SH_W(SW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in                (in),
        .sh                (sh),
        .rotate_en         (rotate_en),
        .shift_left_right  (shift_left_right),
        .rotate_left_right (rotate_left_right),
        .out_valid         (out_valid),
        .out               (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        int           amt;
        logic         rot;
        logic         left;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [32];

    // Reference: each output bit computed from the mode rules with modular indices.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s,
                                           input logic rot, input logic left);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (rot) begin
                if (left) r[i] = d[(i - s + W) % W];
                else      r[i] = d[(i + s) % W];
            end else begin
                if (left) r[i] = (i - s >= 0) ? d[i - s] : 1'b0;
                else      r[i] = (i + s < W)  ? d[i + s] : 1'b0;
            end
        end
        return r;
    endfunction

    task automatic check8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one operation; the unused direction bit is driven X.
    task automatic drive(input logic v, input logic [W-1:0] d, input int s,
                         input logic rot, input logic left);
        logic [31:0] s32;
        s32 = s;
        in_valid  = v;
        in        = d;
        sh        = s32[SW-1:0];
        rotate_en = rot;
        if (rot) begin
            rotate_left_right = left;
            shift_left_right  = 1'bx;
        end else begin
            shift_left_right  = left;
            rotate_left_right = 1'bx;
        end
    endtask

    initial begin
        logic [W-1:0] rl [8];
        logic [W-1:0] rr [8];
        logic [W-1:0] sr [8];
        logic [W-1:0] sl [8];
        logic [W-1:0] exp_out;
        logic [31:0]  r32;
        logic         v;
        logic         rot;
        logic         lft;
        int           s;

        checks = 0;
        errors = 0;

        rl = '{8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C, 8'h78};
        rr = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h87, 8'hC3, 8'hE1};
        sr = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h07, 8'h03, 8'h01};
        sl = '{8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            vecs[i]      = '{din: 8'hF0, amt: i, rot: 1'b1, left: 1'b1, exp: rl[i]};
            vecs[8 + i]  = '{din: 8'hF0, amt: i, rot: 1'b1, left: 1'b0, exp: rr[i]};
            vecs[16 + i] = '{din: 8'hF0, amt: i, rot: 1'b0, left: 1'b0, exp: sr[i]};
            vecs[24 + i] = '{din: 8'hF0, amt: i, rot: 1'b0, left: 1'b1, exp: sl[i]};
        end

        // Power-on reset
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 0, 1'b0, 1'b0);
        #2;
        check8("por_out", out, 8'h00);
        check1("por_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, back to back
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, vecs[i].din, vecs[i].amt, vecs[i].rot, vecs[i].left);
            @(posedge clk); #1;
            check8($sformatf("vec%0d_out", i), out, vecs[i].exp);
            check1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
        end

        // in_valid 1,0,1: out holds across the idle cycle
        drive(1'b1, 8'hA5, 1, 1'b1, 1'b1);
        @(posedge clk); #1;
        check8("tog1_out", out, 8'h4B);
        check1("tog1_valid", out_valid, 1'b1);
        drive(1'b0, 8'h3C, 2, 1'b0, 1'b1);
        @(posedge clk); #1;
        check8("tog2_hold", out, 8'h4B);
        check1("tog2_valid", out_valid, 1'b0);
        drive(1'b1, 8'h81, 3, 1'b0, 1'b0);
        @(posedge clk); #1;
        check8("tog3_out", out, 8'h10);
        check1("tog3_valid", out_valid, 1'b1);

        // Asynchronous reset mid-stream with in_valid high
        drive(1'b1, 8'hFF, 1, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check8("rst_out", out, 8'h00);
        check1("rst_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check8("rst_hold_out", out, 8'h00);
        check1("rst_hold_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h12, 4, 1'b1, 1'b0);
        @(posedge clk); #1;
        check8("post_rst_out", out, 8'h21);
        check1("post_rst_valid", out_valid, 1'b1);
        exp_out = 8'h21;

        // Random stream against the reference model
        for (int n = 0; n < 400; n++) begin
            r32 = $urandom;
            v   = (r32[1:0] != 2'b00);
            rot = r32[2];
            lft = r32[3];
            s   = int'(r32[6:4]);
            drive(v, r32[15:8], s, rot, lft);
            if (v) exp_out = model(r32[15:8], s, rot, lft);
            @(posedge clk); #1;
            check8($sformatf("rnd%0d_out", n), out, exp_out);
            check1($sformatf("rnd%0d_valid", n), out_valid, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_barrel_shifter_unit

// File: doc/barrel_shifter_unit.md
Name: barrel_shifter_unit

Overview:
- Registered N-bit barrel shifter/rotator for the MIPS-style datapath; sits beside the ALU and serves shift/rotate instructions.
- Computes a logical shift or a rotate, left or right, by a 0..WIDTH-1 amount in one log-depth combinational network.
- The result is registered, giving fixed 1-cycle latency with a valid flag.

Parameters:
- WIDTH, 8: data width in bits; must be a power of two, >= 2.
- SH_W, $clog2(WIDTH) (3 for default): width of the shift-amount port.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in/sh/control for capture this cycle.
- in  input  WIDTH  operand.
- sh  input  SH_W  shift/rotate amount, unsigned, 0..WIDTH-1.
- rotate_en  input  1  1 = rotate, 0 = logical shift.
- shift_left_right  input  1  direction used in shift mode: 1 = left, 0 = right.
- rotate_left_right  input  1  direction used in rotate mode: 1 = left, 0 = right.
- out_valid  output  1  out holds a new result.
- out  output  WIDTH  registered result.

Behaviour:
- Reset (rst_n low, asynchronous, any time): out = 0 and out_valid = 0 immediately. Both hold until the first rising clk edge after rst_n deasserts. A result in flight is discarded.
- Latency: exactly 1 cycle. Inputs sampled at edge k produce out/out_valid after edge k. No back-pressure; one operation accepted per cycle.
- out_valid <= in_valid every edge.
- out updates only when in_valid = 1; otherwise out holds its previous value.
- Only the direction bit of the selected mode is used. The other direction bit is don't-care and may be X without affecting out (the bench drives X on it).
- Rotate left by s: out[i] = in[(i - s) mod WIDTH].
- Rotate right by s: out[i] = in[(i + s) mod WIDTH].
- Logical shift left by s: in << s, zero-filled from the LSB.
- Logical shift right by s: in >> s, zero-filled from the MSB. There is no arithmetic (sign-fill) mode.
- sh = 0: out = in in all modes.
- sh is never >= WIDTH by construction, since it is SH_W bits wide; no saturation logic is required.
- Implementation: SH_W mux stages. Stage j conditionally moves the data by 2^j under sh[j], fed with wrap bits (rotate) or zeros (shift). No multiplier or variable `<<` on the full amount.
- Back-to-back operations with differing mode/direction/amount each produce an independent result on consecutive cycles.

Decomposition:
- Shared package shifter_pkg: constants DIR_LEFT = 1'b1, DIR_RIGHT = 1'b0, MODE_ROTATE = 1'b1, MODE_SHIFT = 1'b0.
- One combinational sub-module barrel_shift_comb (parameters WIDTH/SH_W; ports in, sh, rotate_en, left, out) holds the log-stage network.
- The top selects the effective direction bit and owns the output registers.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with in_valid = 1 -> out = 0x00 and out_valid = 0 immediately. First result appears 1 cycle after release.
- Rotate left, in = 0xF0, shift_left_right = X, sh = 0..7 -> F0, E1, C3, 87, 0F, 1E, 3C, 78 (each 1 cycle after its input).
- Rotate right, in = 0xF0, sh = 0..7 -> F0, 78, 3C, 1E, 0F, 87, C3, E1.
- Logical shift right, in = 0xF0, rotate_left_right = X, sh = 0..7 -> F0, 78, 3C, 1E, 0F, 07, 03, 01.
- Logical shift left, in = 0xF0, sh = 0..7 -> F0, E0, C0, 80, 00, 00, 00, 00.
- in_valid toggling 1,0,1 with changing operands -> out holds across the idle cycle. out_valid pattern is 1,0,1 delayed one cycle. Back-to-back results are correct with no bubbles.
